mem_stage: RTL



---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage MIPS32 pipeline.
//
// Takes the EX-stage result and performs lw/sw against an internal
// word-addressed data memory of 2**ADDR_W 32-bit words. It registers the
// MEM/WB fields that wb_stage consumes. A variable-latency memory is modelled
// by holding `stall` high for MEM_LATENCY cycles per memory op.
//
// Handshake: an instruction is accepted at the rising edge that ends a cycle
// with in_valid=1 and stall=0. While stall is high, upstream holds every
// input steady. The stage samples its inputs only at the accept edge.
//
// Optional build macro MEM_BYTE_OPS_EN adds lb (sign-extended byte load) and
// sb (byte store), using little-endian byte lanes selected by alu_result[1:0].
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   in_valid                 EX/MEM fields carry a real instruction
//   opcode, Instruction_type instruction opcode and type (11 = I-type)
//   rd_add, rt_add           destination register indices
//   alu_result               ALU output; byte address for memory ops
//   store_data               rt value written by stores
//   stall                    combinational; upstream must hold inputs
//   out_valid .. write_data  registered MEM/WB pipeline fields
//   misalign                 registered; accepted lw/sw had a misaligned address
//   fsm_state                debug view of the FSM (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [1:0]  Instruction_type,
  input  logic [4:0]  rd_add,
  input  logic [4:0]  rt_add,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        out_valid,
  output logic [5:0]  opcode_out,
  output logic [1:0]  Instruction_type_out,
  output logic [4:0]  rd_add_out,
  output logic [4:0]  rt_add_out,
  output logic [31:0] write_data,
  output logic        misalign,
  output logic        fsm_state
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
`ifdef MEM_BYTE_OPS_EN
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SB = 6'b101000;
`endif
  localparam logic [1:0] TYPE_I      = 2'b11;
  localparam logic [1:0] TYPE_BUBBLE = 2'b01;
  // The IDLE cycle that first sees the op is the first stall cycle, so the
  // WAIT state only has to count down the remaining MEM_LATENCY-1 of them.
  localparam logic [3:0] WAIT_INIT   = 4'(MEM_LATENCY - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       stall_c;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              aligned;
  logic              is_lw, is_sw, is_lb, is_sb, is_mem;
  logic              accept;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;

  // Upper address bits are ignored on purpose: the address wraps around.
  logic unused_addr;
  assign unused_addr = &{1'b0, alu_result[31:ADDR_W+2]};

  assign idx     = alu_result[ADDR_W+1:2];
  assign lane    = alu_result[1:0];
  assign aligned = (lane == 2'b00);
  assign is_lw   = (Instruction_type == TYPE_I) && (opcode == OP_LW);
  assign is_sw   = (Instruction_type == TYPE_I) && (opcode == OP_SW);
`ifdef MEM_BYTE_OPS_EN
  assign is_lb   = (Instruction_type == TYPE_I) && (opcode == OP_LB);
  assign is_sb   = (Instruction_type == TYPE_I) && (opcode == OP_SB);
`else
  assign is_lb   = 1'b0;
  assign is_sb   = 1'b0;
`endif
  assign is_mem  = is_lw | is_sw | is_lb | is_sb;
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------- FSM: next state / stall ----------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && is_mem && (MEM_LATENCY > 0)) begin
          stall_c    = 1'b1;
          state_next = S_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          stall_c  = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          // Stall drops for this cycle; the op is accepted at its end.
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stall     = stall_c & ~rst;
  assign accept    = in_valid & ~stall & ~rst;
  assign fsm_state = state;

  // ---------------- Data memory (not reset) ----------------
  always_ff @(posedge clk) begin
    if (accept) begin
      if (is_sw && aligned) mem[idx] <= store_data;
      if (is_sb)            mem[idx][{lane, 3'b000} +: 8] <= store_data[7:0];
    end
  end

  // ---------------- MEM/WB pipeline register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid            <= 1'b0;
      opcode_out           <= 6'd0;
      Instruction_type_out <= TYPE_BUBBLE;
      rd_add_out           <= 5'd0;
      rt_add_out           <= 5'd0;
      write_data           <= 32'd0;
      misalign             <= 1'b0;
    end else if (accept) begin
      out_valid            <= 1'b1;
      opcode_out           <= opcode;
      Instruction_type_out <= Instruction_type;
      rd_add_out           <= rd_add;
      rt_add_out           <= rt_add;
      misalign             <= (is_lw | is_sw) & ~aligned;
      if (is_lw)      write_data <= aligned ? rd_word : 32'd0;
      else if (is_lb) write_data <= {{24{rd_byte[7]}}, rd_byte};
      else            write_data <= alu_result;
    end else begin
      // Bubble: wb_stage must not write; the remaining fields hold.
      out_valid            <= 1'b0;
      Instruction_type_out <= TYPE_BUBBLE;
    end
  end

endmodule
